// File: rtl/trace_encoder.sv
// trace_encoder: retirement-trace packetiser at the commit point.
// Each qualifying retirement becomes a header word (type index, trap info,
// privilege, sequence number) plus a PC word. Packets queue in a small FIFO
// and are streamed out one 32-bit word per valid/ready handshake.
// Optional feature macro: TRACE_TIMESTAMP_EN adds a third word per packet
// carrying a free-running 32-bit cycle stamp captured at retirement.
module trace_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int SEQ_WIDTH  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_i,
    input  logic        retire_valid_i,
    input  logic [31:0] retire_pc_i,
    input  logic [63:0] retire_itype_i,
    input  logic        retire_exception_i,
    input  logic [4:0]  retire_exc_code_i,
    input  logic        retire_interrupt_i,
    input  logic [4:0]  retire_int_code_i,
    input  logic [1:0]  privilege_i,
    input  logic        overflow_clr_i,
    output logic        trace_valid_o,
    output logic [31:0] trace_data_o,
    output logic        trace_last_o,
    input  logic        trace_ready_i,
    output logic        overflow_o,
    output logic [15:0] dropped_count_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

`ifdef TRACE_TIMESTAMP_EN
    typedef enum logic [1:0] {T_IDLE, T_HDR, T_PC, T_TS} state_t;
    localparam state_t LAST_STATE = T_TS;
`else
    typedef enum logic [1:0] {T_IDLE, T_HDR, T_PC} state_t;
    localparam state_t LAST_STATE = T_PC;
`endif

    state_t            state_reg;
    logic [SEQ_WIDTH-1:0] seq_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic [31:0]       hdr_mem [FIFO_DEPTH];
    logic [31:0]       pc_mem  [FIFO_DEPTH];

    // ---------------- type encoding ----------------
    // Bit gi of the index is the OR of every itype bit whose position has bit gi set;
    // exact for a one-hot input, overridden to INVALID otherwise.
    logic [5:0] onehot_idx;
    for (genvar gi = 0; gi < 6; gi++) begin : g_idx
        logic [63:0] sel_mask;
        always_comb begin
            sel_mask = '0;
            for (int b = 0; b < 64; b++) sel_mask[b] = b[gi];
        end
        assign onehot_idx[gi] = |(retire_itype_i & sel_mask);
    end

    logic       itype_any;
    logic       itype_multi;
    logic       malformed;
    logic [5:0] type_idx;
    logic [4:0] cause;
    logic [15:0] seq16;
    logic [31:0] header_word;

    assign itype_any   = |retire_itype_i;
    assign itype_multi = |(retire_itype_i & (retire_itype_i - 64'd1));
    assign malformed   = !itype_any || itype_multi;
    assign type_idx    = malformed ? 6'd7 : onehot_idx;
    assign cause       = retire_exception_i ? retire_exc_code_i :
                         retire_interrupt_i ? retire_int_code_i : 5'd0;

    if (SEQ_WIDTH >= 16) begin : g_seq_trunc
        assign seq16 = seq_reg[15:0];
    end else begin : g_seq_pad
        assign seq16 = {{(16-SEQ_WIDTH){1'b0}}, seq_reg};
    end

    assign header_word = {type_idx, retire_exception_i, retire_interrupt_i, cause,
                          privilege_i, malformed, seq16};

    // ---------------- push / pop decisions ----------------
    logic qualify;
    logic full;
    logic pop;
    logic push;
    logic drop;
    logic [PTR_W-1:0] rd_next_ptr;

    assign qualify     = retire_valid_i && enable_i;
    assign full        = (count_reg == DEPTH_CNT);
    assign pop         = (state_reg == LAST_STATE) && trace_ready_i;
    assign push        = qualify && (!full || pop);
    assign drop        = qualify && !push;
    assign rd_next_ptr = rd_ptr_reg + PTR_W'(1);

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] ts_reg;
    logic [31:0] ts_mem [FIFO_DEPTH];

    // Free-running cycle stamp, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) ts_reg <= '0;
        else       ts_reg <= ts_reg + 32'd1;
    end

    // Timestamp storage alongside the packet entry.
    always_ff @(posedge clk) begin
        if (push) ts_mem[wr_ptr_reg] <= ts_reg;
    end
`endif

    // Packet storage; no reset needed, occupancy is tracked by count_reg.
    always_ff @(posedge clk) begin
        if (push) begin
            hdr_mem[wr_ptr_reg] <= header_word;
            pc_mem[wr_ptr_reg]  <= retire_pc_i;
        end
    end

    // FIFO pointers, occupancy and sequence counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            seq_reg    <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_next_ptr;
            if (push && !pop)      count_reg <= count_reg + (PTR_W+1)'(1);
            else if (pop && !push) count_reg <= count_reg - (PTR_W+1)'(1);
            if (qualify) seq_reg <= seq_reg + SEQ_WIDTH'(1);
        end
    end

    // Sticky overflow flag and saturating drop counter; a drop beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_o      <= 1'b0;
            dropped_count_o <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (overflow_clr_i)                 dropped_count_o <= 16'd1;
            else if (dropped_count_o != 16'hFFFF) dropped_count_o <= dropped_count_o + 16'd1;
        end else if (overflow_clr_i) begin
            overflow_o      <= 1'b0;
            dropped_count_o <= '0;
        end
    end

    // Serializer FSM with registered stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= T_IDLE;
            trace_valid_o <= 1'b0;
            trace_data_o  <= '0;
            trace_last_o  <= 1'b0;
        end else if (pop) begin
            if (count_reg > (PTR_W+1)'(1)) begin
                state_reg    <= T_HDR;
                trace_data_o <= hdr_mem[rd_next_ptr];
                trace_last_o <= 1'b0;
            end else begin
                state_reg     <= T_IDLE;
                trace_valid_o <= 1'b0;
                trace_data_o  <= '0;
                trace_last_o  <= 1'b0;
            end
        end else begin
            case (state_reg)
                T_IDLE: if (count_reg != '0) begin
                    state_reg     <= T_HDR;
                    trace_valid_o <= 1'b1;
                    trace_data_o  <= hdr_mem[rd_ptr_reg];
                    trace_last_o  <= 1'b0;
                end
                T_HDR: if (trace_ready_i) begin
                    state_reg    <= T_PC;
                    trace_data_o <= pc_mem[rd_ptr_reg];
`ifdef TRACE_TIMESTAMP_EN
                    trace_last_o <= 1'b0;
`else
                    trace_last_o <= 1'b1;
`endif
                end
`ifdef TRACE_TIMESTAMP_EN
                T_PC: if (trace_ready_i) begin
                    state_reg    <= T_TS;
                    trace_data_o <= ts_mem[rd_ptr_reg];
                    trace_last_o <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_trace_encoder.sv
// tb_trace_encoder: randomized scoreboard bench for trace_encoder.
module tb_trace_encoder;
    localparam int DEPTH = 4;
`ifdef TRACE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif
    localparam logic [63:0] ADD   = 64'h100;
    localparam logic [63:0] ECALL = 64'h20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable_i = 1'b0;
    logic        retire_valid_i = 1'b0;
    logic [31:0] retire_pc_i = '0;
    logic [63:0] retire_itype_i = '0;
    logic        retire_exception_i = 1'b0;
    logic [4:0]  retire_exc_code_i = '0;
    logic        retire_interrupt_i = 1'b0;
    logic [4:0]  retire_int_code_i = '0;
    logic [1:0]  privilege_i = '0;
    logic        overflow_clr_i = 1'b0;
    logic        trace_valid_o;
    logic [31:0] trace_data_o;
    logic        trace_last_o;
    logic        trace_ready_i = 1'b0;
    logic        overflow_o;
    logic [15:0] dropped_count_o;

    trace_encoder #(.FIFO_DEPTH(DEPTH), .SEQ_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .enable_i(enable_i),
        .retire_valid_i(retire_valid_i), .retire_pc_i(retire_pc_i),
        .retire_itype_i(retire_itype_i), .retire_exception_i(retire_exception_i),
        .retire_exc_code_i(retire_exc_code_i), .retire_interrupt_i(retire_interrupt_i),
        .retire_int_code_i(retire_int_code_i), .privilege_i(privilege_i),
        .overflow_clr_i(overflow_clr_i), .trace_valid_o(trace_valid_o),
        .trace_data_o(trace_data_o), .trace_last_o(trace_last_o),
        .trace_ready_i(trace_ready_i), .overflow_o(overflow_o),
        .dropped_count_o(dropped_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } word_t;

    word_t       exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          occ = 0;
    logic [15:0] seq = '0;
    logic        exp_ovf = 1'b0;
    logic [15:0] exp_drop = '0;
    logic [31:0] cyc = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference header: count set bits, pick cause by priority, pack fields.
    function automatic logic [31:0] model_hdr(input logic [63:0] it, input logic exc,
            input logic [4:0] ec, input logic intr, input logic [4:0] ic,
            input logic [1:0] pr, input logic [15:0] s);
        int n = 0;
        int idx = 0;
        logic mal;
        logic [4:0] cause;
        for (int i = 0; i < 64; i++) if (it[i]) begin n++; idx = i; end
        mal = (n != 1);
        if (mal) idx = 7;
        cause = exc ? ec : (intr ? ic : 5'd0);
        return {idx[5:0], exc, intr, cause, pr, mal, s};
    endfunction

    // One clock of stimulus; the model predicts the effect of the coming edge.
    task automatic cycle(input logic rst_v, input logic rv, input logic en,
            input logic [31:0] pc, input logic [63:0] it, input logic exc,
            input logic [4:0] ec, input logic intr, input logic [4:0] ic,
            input logic [1:0] pr, input logic clr, input logic rdy);
        logic pop;
        logic dropped;
        @(negedge clk);
        reset = rst_v; retire_valid_i = rv; enable_i = en; retire_pc_i = pc;
        retire_itype_i = it; retire_exception_i = exc; retire_exc_code_i = ec;
        retire_interrupt_i = intr; retire_int_code_i = ic; privilege_i = pr;
        overflow_clr_i = clr; trace_ready_i = rdy;
        #1;
        check("overflow", {31'd0, overflow_o}, {31'd0, exp_ovf});
        check("dropped", {16'd0, dropped_count_o}, {16'd0, exp_drop});
        if (rst_v) begin
            exp_q.delete(); occ = 0; seq = '0; exp_ovf = 1'b0; exp_drop = '0; cyc = '0;
            return;
        end
        pop = trace_valid_o && trace_ready_i && trace_last_o;
        dropped = 1'b0;
        if (rv && en) begin
            if (occ < DEPTH || pop) begin
                exp_q.push_back('{data: model_hdr(it, exc, ec, intr, ic, pr, seq), last: 1'b0});
                exp_q.push_back('{data: pc, last: !TS_EN});
                if (TS_EN) exp_q.push_back('{data: cyc, last: 1'b1});
                occ++;
            end else begin
                dropped = 1'b1;
                exp_ovf = 1'b1;
                exp_drop = clr ? 16'd1 : (exp_drop == 16'hFFFF ? exp_drop : exp_drop + 16'd1);
            end
            seq++;
        end
        if (clr && !dropped) begin exp_ovf = 1'b0; exp_drop = '0; end
        if (pop) occ--;
        cyc++;
    endtask

    task automatic idle(input logic rdy);
        cycle(0, 0, 1, 32'd0, 64'd0, 0, 5'd0, 0, 5'd0, 2'd0, 0, rdy);
    endtask

    task automatic retire(input logic [63:0] it, input logic [31:0] pc, input logic rdy);
        cycle(0, 1, 1, pc, it, 0, 5'd0, 0, 5'd0, 2'd3, 0, rdy);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 32'd0, 64'd0, 0, 5'd0, 0, 5'd0, 2'd0, 0, 0);
        cycle(1, 0, 0, 32'd0, 64'd0, 0, 5'd0, 0, 5'd0, 2'd0, 0, 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || trace_valid_o) && n < 200) begin idle(1); n++; end
        if (n >= 200) check("drain_timeout", exp_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    initial begin
        logic        prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        logic        prev_last = 1'b0;
        word_t       w;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", {31'd0, trace_valid_o}, 32'd1);
                    check("stall_data", trace_data_o, prev_data);
                    check("stall_last", {31'd0, trace_last_o}, {31'd0, prev_last});
                end
                if (trace_valid_o && trace_ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", trace_data_o, 32'hxxxxxxxx);
                    end else begin
                        w = exp_q.pop_front();
                        check("word_data", trace_data_o, w.data);
                        check("word_last", {31'd0, trace_last_o}, {31'd0, w.last});
                    end
                end
                prev_stall = trace_valid_o && !trace_ready_i;
                prev_data  = trace_data_o;
                prev_last  = trace_last_o;
            end
        end
    end

    initial begin
        logic [63:0] it;
        logic [63:0] one;
        one = 64'd1;
        do_reset();
        idle(1);
        check("rst_valid", {31'd0, trace_valid_o}, 32'd0);
        check("rst_data", trace_data_o, 32'd0);
        check("rst_last", {31'd0, trace_last_o}, 32'd0);

        // Single ADD: header two cycles after retirement.
        retire(ADD, 32'h100, 1);
        idle(1);
        check("add_lat_valid", {31'd0, trace_valid_o}, 32'd0);
        idle(1);
        check("add_hdr", trace_data_o, 32'h20060000);
        check("add_hdr_last", {31'd0, trace_last_o}, 32'd0);
        idle(1);
        check("add_pc", trace_data_o, 32'h100);
        check("add_pc_last", {31'd0, trace_last_o}, {31'd0, !TS_EN});
        if (TS_EN) idle(1);
        idle(1);
        check("add_end_valid", {31'd0, trace_valid_o}, 32'd0);

        // ECALL trap from sequence 0.
        do_reset();
        cycle(0, 1, 1, 32'h200, ECALL, 1, 5'd11, 0, 5'd0, 2'd3, 0, 1);
        idle(1); idle(1);
        check("ecall_hdr", trace_data_o, 32'h165E0000);
        drain();

        // Malformed type ADD|SUB.
        retire(64'h300, 32'h300, 1);
        idle(1); idle(1);
        check("malformed_hdr", {16'd0, trace_data_o[31:16]}, 32'h1C07);
        drain();

        // Overflow: six retirements against a stalled sink.
        do_reset();
        for (int i = 0; i < 6; i++) retire(one << (i + 1), 32'h1000 + 32'(i * 4), 0);
        idle(0);
        check("ovf_flag", {31'd0, overflow_o}, 32'd1);
        check("ovf_count", {16'd0, dropped_count_o}, 32'd2);
        drain();
        retire(ADD, 32'h2000, 1);
        idle(1); idle(1);
        check("ovf_next_seq", {16'd0, trace_data_o[15:0]}, 32'd6);
        drain();

        // Clear coinciding with a drop, then a plain clear.
        for (int i = 0; i < 4; i++) retire(ADD, 32'h3000, 0);
        cycle(0, 1, 1, 32'h3004, ADD, 0, 5'd0, 0, 5'd0, 2'd3, 1, 0);
        idle(0);
        check("clr_drop_flag", {31'd0, overflow_o}, 32'd1);
        check("clr_drop_count", {16'd0, dropped_count_o}, 32'd1);
        cycle(0, 0, 1, 32'd0, 64'd0, 0, 5'd0, 0, 5'd0, 2'd0, 1, 0);
        idle(0);
        check("clr_flag", {31'd0, overflow_o}, 32'd0);
        drain();

        // Backpressure 1-0-0-1 within a packet.
        retire(ADD, 32'h4000, 0);
        idle(0); idle(0);
        idle(1); idle(0); idle(0); idle(1);
        drain();

        // Reset during a PC-word stall aborts the packet.
        retire(ADD, 32'h5000, 0);
        idle(0); idle(0); idle(1); idle(0);
        check("pc_stall_data", trace_data_o, 32'h5000);
        cycle(1, 0, 0, 32'd0, 64'd0, 0, 5'd0, 0, 5'd0, 2'd0, 0, 0);
        idle(1);
        check("abort_valid", {31'd0, trace_valid_o}, 32'd0);
        retire(ADD, 32'h6000, 1);
        idle(1); idle(1);
        check("abort_seq", {16'd0, trace_data_o[15:0]}, 32'd0);
        drain();

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 9))
                0: it = '0;
                1: it = (one << $urandom_range(0, 63)) | (one << $urandom_range(0, 63));
                default: it = one << $urandom_range(0, 63);
            endcase
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 9) != 0, $urandom(), it,
                  $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)),
                  2'($urandom_range(0, 3)), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 7);
        end
        drain();
        idle(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
